// File: rtl/approx_mul_err_monitor_if.sv
// rtl/approx_mul_err_monitor_if.sv - sample handshake bus feeding the approximate-multiplier error monitor
interface approx_mul_err_monitor_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] approx_prod;

    modport master (output in_valid, output op_a, output op_b, output approx_prod, input in_ready);
    modport slave  (input in_valid, input op_a, input op_b, input approx_prod, output in_ready);
endinterface

// File: rtl/approx_mul_err_monitor.sv
// rtl/approx_mul_err_monitor.sv - error statistics over a run of approximate 8x8 products
// Optional worst-case operand capture is enabled by defining ERR_MON_WORST_CASE_EN.
module approx_mul_err_monitor #(
    parameter int WIDTH       = 8,
    parameter int NUM_SAMPLES = 65536,
    parameter int ACC_W       = 48,
    parameter int CNT_W       = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    approx_mul_err_monitor_if.slave in_if,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        sample_cnt,
    output logic [CNT_W-1:0]        mismatch_cnt,
    output logic [ACC_W-1:0]        sum_err,
    output logic [ACC_W-1:0]        sum_sq_err,
    output logic [2*WIDTH:0]        max_abs_err
`ifdef ERR_MON_WORST_CASE_EN
    ,
    output logic [WIDTH-1:0]        worst_a,
    output logic [WIDTH-1:0]        worst_b,
    output logic [2*WIDTH-1:0]      worst_approx
`endif
);
    localparam int PW = 2 * WIDTH;
    localparam int EW = PW + 1;
    localparam int SW = 2 * EW;
    localparam logic [CNT_W-1:0] N_LIM = CNT_W'(NUM_SAMPLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic               s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [PW-1:0]      s1_p_q, s1_p_d;
    logic [EW-1:0]      s2_err_q, s2_err_d, s2_abs_q, s2_abs_d;
    logic [EW-1:0]      s3_err_q, s3_err_d, s3_abs_q, s3_abs_d;
    logic [SW-1:0]      s3_sq_q, s3_sq_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
    logic [ACC_W-1:0]   sum_err_q, sum_err_d, sum_sq_q, sum_sq_d;
    logic [EW-1:0]      max_abs_q, max_abs_d;
`ifdef ERR_MON_WORST_CASE_EN
    logic [WIDTH-1:0]   s2_a_q, s2_a_d, s2_b_q, s2_b_d, s3_a_q, s3_a_d, s3_b_q, s3_b_d;
    logic [PW-1:0]      s2_p_q, s2_p_d, s3_p_q, s3_p_d;
    logic [WIDTH-1:0]   worst_a_q, worst_a_d, worst_b_q, worst_b_d;
    logic [PW-1:0]      worst_p_q, worst_p_d;
`endif

    logic               in_ready, hs;
    logic [PW-1:0]      exact_c;
    logic [EW-1:0]      err_c, abs_c;
    logic [ACC_W:0]     sum_ext, sq_ext;

    assign in_ready       = (state_q == S_RUN) && (issued_q < N_LIM);
    assign hs             = in_if.in_valid && in_ready && !start;
    assign in_if.in_ready = in_ready;

    assign exact_c = PW'(s1_a_q) * PW'(s1_b_q);
    assign err_c   = {1'b0, s1_p_q} - {1'b0, exact_c};
    assign abs_c   = err_c[EW-1] ? (~err_c + EW'(1)) : err_c;

    // One guard bit above each accumulator detects overflow for saturation.
    assign sum_ext = {sum_err_q[ACC_W-1], sum_err_q} + {{(ACC_W+1-EW){s3_err_q[EW-1]}}, s3_err_q};
    assign sq_ext  = {1'b0, sum_sq_q} + {{(ACC_W+1-SW){1'b0}}, s3_sq_q};

    always_comb begin
        state_d        = state_q;
        issued_d       = issued_q;
        s1_vld_d       = hs;
        s1_a_d         = s1_a_q;
        s1_b_d         = s1_b_q;
        s1_p_d         = s1_p_q;
        s2_vld_d       = s1_vld_q;
        s2_err_d       = err_c;
        s2_abs_d       = abs_c;
        s3_vld_d       = s2_vld_q;
        s3_err_d       = s2_err_q;
        s3_abs_d       = s2_abs_q;
        s3_sq_d        = SW'(s2_abs_q) * SW'(s2_abs_q);
        sample_cnt_d   = sample_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        sum_err_d      = sum_err_q;
        sum_sq_d       = sum_sq_q;
        max_abs_d      = max_abs_q;
`ifdef ERR_MON_WORST_CASE_EN
        s2_a_d    = s1_a_q;
        s2_b_d    = s1_b_q;
        s2_p_d    = s1_p_q;
        s3_a_d    = s2_a_q;
        s3_b_d    = s2_b_q;
        s3_p_d    = s2_p_q;
        worst_a_d = worst_a_q;
        worst_b_d = worst_b_q;
        worst_p_d = worst_p_q;
`endif

        if (hs) begin
            s1_a_d   = in_if.op_a;
            s1_b_d   = in_if.op_b;
            s1_p_d   = in_if.approx_prod;
            issued_d = issued_q + CNT_W'(1);
        end

        if (s3_vld_q) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (s3_err_q != '0)
                mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
            if (sum_ext[ACC_W] != sum_ext[ACC_W-1])
                sum_err_d = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else
                sum_err_d = sum_ext[ACC_W-1:0];
            sum_sq_d = sq_ext[ACC_W] ? {ACC_W{1'b1}} : sq_ext[ACC_W-1:0];
            // Strict compare: the first sample reaching a new maximum is kept on ties.
            if (s3_abs_q > max_abs_q) begin
                max_abs_d = s3_abs_q;
`ifdef ERR_MON_WORST_CASE_EN
                worst_a_d = s3_a_q;
                worst_b_d = s3_b_q;
                worst_p_d = s3_p_q;
`endif
            end
        end

        case (state_q)
            S_RUN:   if (issued_q == N_LIM) state_d = S_DRAIN;
            S_DRAIN: if (!(s1_vld_q || s2_vld_q || s3_vld_q)) state_d = S_DONE;
            default: state_d = state_q;
        endcase

        if (start) begin
            state_d        = S_RUN;
            issued_d       = '0;
            s1_vld_d       = 1'b0;
            s2_vld_d       = 1'b0;
            s3_vld_d       = 1'b0;
            sample_cnt_d   = '0;
            mismatch_cnt_d = '0;
            sum_err_d      = '0;
            sum_sq_d       = '0;
            max_abs_d      = '0;
`ifdef ERR_MON_WORST_CASE_EN
            worst_a_d = '0;
            worst_b_d = '0;
            worst_p_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            issued_q       <= '0;
            s1_vld_q       <= 1'b0;
            s2_vld_q       <= 1'b0;
            s3_vld_q       <= 1'b0;
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s1_p_q         <= '0;
            s2_err_q       <= '0;
            s2_abs_q       <= '0;
            s3_err_q       <= '0;
            s3_abs_q       <= '0;
            s3_sq_q        <= '0;
            sample_cnt_q   <= '0;
            mismatch_cnt_q <= '0;
            sum_err_q      <= '0;
            sum_sq_q       <= '0;
            max_abs_q      <= '0;
`ifdef ERR_MON_WORST_CASE_EN
            s2_a_q    <= '0;
            s2_b_q    <= '0;
            s2_p_q    <= '0;
            s3_a_q    <= '0;
            s3_b_q    <= '0;
            s3_p_q    <= '0;
            worst_a_q <= '0;
            worst_b_q <= '0;
            worst_p_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            issued_q       <= issued_d;
            s1_vld_q       <= s1_vld_d;
            s2_vld_q       <= s2_vld_d;
            s3_vld_q       <= s3_vld_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_p_q         <= s1_p_d;
            s2_err_q       <= s2_err_d;
            s2_abs_q       <= s2_abs_d;
            s3_err_q       <= s3_err_d;
            s3_abs_q       <= s3_abs_d;
            s3_sq_q        <= s3_sq_d;
            sample_cnt_q   <= sample_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            sum_err_q      <= sum_err_d;
            sum_sq_q       <= sum_sq_d;
            max_abs_q      <= max_abs_d;
`ifdef ERR_MON_WORST_CASE_EN
            s2_a_q    <= s2_a_d;
            s2_b_q    <= s2_b_d;
            s2_p_q    <= s2_p_d;
            s3_a_q    <= s3_a_d;
            s3_b_q    <= s3_b_d;
            s3_p_q    <= s3_p_d;
            worst_a_q <= worst_a_d;
            worst_b_q <= worst_b_d;
            worst_p_q <= worst_p_d;
`endif
        end
    end

    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign sample_cnt   = sample_cnt_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign sum_err      = sum_err_q;
    assign sum_sq_err   = sum_sq_q;
    assign max_abs_err  = max_abs_q;
`ifdef ERR_MON_WORST_CASE_EN
    assign worst_a      = worst_a_q;
    assign worst_b      = worst_b_q;
    assign worst_approx = worst_p_q;
`endif
endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// tb/tb_approx_mul_err_monitor.sv - scoreboard bench for approx_mul_err_monitor with a run-level reference model
module tb_approx_mul_err_monitor;
    localparam int WIDTH = 8;
    localparam int NS    = 4;
    localparam int ACC_W = 48;
    localparam int CNT_W = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;
    logic [CNT_W-1:0]   sample_cnt, mismatch_cnt;
    logic [ACC_W-1:0]   sum_err, sum_sq_err;
    logic [2*WIDTH:0]   max_abs_err;
`ifdef ERR_MON_WORST_CASE_EN
    logic [WIDTH-1:0]   worst_a, worst_b;
    logic [2*WIDTH-1:0] worst_approx;
`endif

    approx_mul_err_monitor_if #(.WIDTH(WIDTH)) bus ();

    approx_mul_err_monitor #(
        .WIDTH(WIDTH), .NUM_SAMPLES(NS), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_if        (bus),
        .busy         (busy),
        .done         (done),
        .sample_cnt   (sample_cnt),
        .mismatch_cnt (mismatch_cnt),
        .sum_err      (sum_err),
        .sum_sq_err   (sum_sq_err),
        .max_abs_err  (max_abs_err)
`ifdef ERR_MON_WORST_CASE_EN
        ,
        .worst_a      (worst_a),
        .worst_b      (worst_b),
        .worst_approx (worst_approx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint cnt;
        longint mism;
        longint sum;
        longint sq;
        longint maxabs;
        int     wa;
        int     wb;
        int     wp;
    } exp_t;

    exp_t exp_q[$];
    int   ra[$], rb[$], rp[$];
    int   n_checks = 0;
    int   n_errs = 0;
    bit   expect_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Statistics of a whole run straight from the definition of error.
    function automatic exp_t model();
        exp_t   e;
        longint err, ab;
        e = '{default: 0};
        foreach (ra[i]) begin
            err = longint'(rp[i]) - longint'(ra[i]) * longint'(rb[i]);
            ab  = (err < 0) ? -err : err;
            e.cnt++;
            e.sum += err;
            e.sq  += ab * ab;
            if (err != 0) e.mism++;
            if (ab > e.maxabs) begin
                e.maxabs = ab;
                e.wa = ra[i];
                e.wb = rb[i];
                e.wp = rp[i];
            end
        end
        return e;
    endfunction

    task automatic record(input int a, input int b, input int p);
        ra.push_back(a);
        rb.push_back(b);
        rp.push_back(p);
        if (ra.size() == NS && expect_en) exp_q.push_back(model());
    endtask

    task automatic clear_run();
        ra.delete();
        rb.delete();
        rp.delete();
    endtask

    task automatic do_start();
        bus.in_valid = 1'b0;
        start = 1'b1;
        clear_run();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int p);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.op_a = a[WIDTH-1:0];
        bus.op_b = b[WIDTH-1:0];
        bus.approx_prod = p[2*WIDTH-1:0];
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) record(a, b, p);
        else chk("send_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic rand_sample(output int a, output int b, output int p);
        int k, d;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        k = $urandom_range(0, 3);
        d = $urandom_range(1, 300);
        p = a * b;
        if (k == 1) p = $urandom_range(0, 65535);
        else if (k == 2) p = (a * b + d) % 65536;
        else if (k == 3 && p >= d) p = p - d;
    endtask

    task automatic send_rand();
        int a, b, p, gap;
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        rand_sample(a, b, p);
        send(a, b, p);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", 64'(done), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
        chk({tag, "_mismatch_cnt"}, 64'(mismatch_cnt), 64'd0);
        chk({tag, "_sum_err"}, 64'(sum_err), 64'd0);
        chk({tag, "_sum_sq_err"}, 64'(sum_sq_err), 64'd0);
        chk({tag, "_max_abs_err"}, 64'(max_abs_err), 64'd0);
    endtask

    // Monitor: every rising done retires one expected run from the scoreboard.
    initial begin
        bit               done_prev;
        exp_t             e;
        logic [ACC_W-1:0] es;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 64'd1, 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    es = ACC_W'(e.sum);
                    chk("sb_busy_low", 64'(busy), 64'd0);
                    chk("sb_sample_cnt", 64'(sample_cnt), 64'(e.cnt));
                    chk("sb_mismatch_cnt", 64'(mismatch_cnt), 64'(e.mism));
                    chk("sb_sum_err", 64'(sum_err), 64'(es));
                    chk("sb_sum_sq_err", 64'(sum_sq_err), 64'(e.sq));
                    chk("sb_max_abs_err", 64'(max_abs_err), 64'(e.maxabs));
`ifdef ERR_MON_WORST_CASE_EN
                    chk("sb_worst_a", 64'(worst_a), 64'(e.wa));
                    chk("sb_worst_b", 64'(worst_b), 64'(e.wb));
                    chk("sb_worst_approx", 64'(worst_approx), 64'(e.wp));
`endif
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        int               a, b, p, acc;
        logic [ACC_W-1:0] lat_exp;
        bus.in_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.approx_prod = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'd0);

        // Exact products only: every statistic but the count stays zero.
        do_start();
        send(3, 5, 15);
        send(255, 255, 65025);
        send(0, 7, 0);
        send(1, 1, 1);
        wait_done();

        // Errors -2, +4, 0 plus an exact filler sample.
        do_start();
        send(3, 5, 13);
        send(10, 10, 104);
        send(2, 2, 4);
        send(0, 0, 0);
        wait_done();
        chk("t2_sum_err", 64'(sum_err), 64'd2);
        chk("t2_sum_sq_err", 64'(sum_sq_err), 64'd20);
        chk("t2_mismatch_cnt", 64'(mismatch_cnt), 64'd2);
        chk("t2_max_abs_err", 64'(max_abs_err), 64'd4);
`ifdef ERR_MON_WORST_CASE_EN
        chk("t2_worst_a", 64'(worst_a), 64'd10);
        chk("t2_worst_b", 64'(worst_b), 64'd10);
        chk("t2_worst_approx", 64'(worst_approx), 64'd104);
`endif

        // Latency: accepted at edge t, visible only after edge t+3.
        do_start();
        send(255, 255, 0);
        @(negedge clk);
        @(negedge clk);
        chk("lat_early_sample_cnt", 64'(sample_cnt), 64'd0);
        chk("lat_early_sum_err", 64'(sum_err), 64'd0);
        @(negedge clk);
        lat_exp = ACC_W'(0) - ACC_W'(65025);
        chk("lat_sum_err", 64'(sum_err), 64'(lat_exp));
        chk("lat_sum_sq_err", 64'(sum_sq_err), 64'd4228250625);
        chk("lat_sample_cnt", 64'(sample_cnt), 64'd1);
        repeat (NS - 1) send_rand();
        wait_done();

        // in_valid held high: only NS handshakes may happen.
        do_start();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            rand_sample(a, b, p);
            bus.in_valid = 1'b1;
            bus.op_a = a[WIDTH-1:0];
            bus.op_b = b[WIDTH-1:0];
            bus.approx_prod = p[2*WIDTH-1:0];
            if (bus.in_ready) begin
                acc++;
                record(a, b, p);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("hold_accepted", 64'(acc), 64'(NS));
        wait_done();
        chk("hold_busy", 64'(busy), 64'd0);
        chk("hold_done", 64'(done), 64'd1);

        // start after two samples, with a concurrent handshake that must be dropped.
        do_start();
        send_rand();
        send_rand();
        rand_sample(a, b, p);
        bus.in_valid = 1'b1;
        bus.op_a = a[WIDTH-1:0];
        bus.op_b = b[WIDTH-1:0];
        bus.approx_prod = p[2*WIDTH-1:0];
        chk("abort_ready_at_start", 64'(bus.in_ready), 64'd1);
        start = 1'b1;
        clear_run();
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_busy", 64'(busy), 64'd1);
        chk_all_zero("abort");
        repeat (3) @(negedge clk);
        chk("abort_inflight_dropped", 64'(sample_cnt), 64'd0);
        chk("abort_done_low", 64'(done), 64'd0);
        repeat (NS) send_rand();
        wait_done();

        for (int r = 0; r < 6; r++) begin
            do_start();
            repeat (NS) send_rand();
            wait_done();
        end

        // Reset during DRAIN discards the run entirely.
        expect_en = 1'b0;
        do_start();
        repeat (NS) send_rand();
        @(negedge clk);
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("drst_busy", 64'(busy), 64'd0);
        chk("drst_done", 64'(done), 64'd0);
        chk_all_zero("drst");
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drst_in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("drst_ignored_samples", 64'(sample_cnt), 64'd0);
        chk("drst_done_stays_low", 64'(done), 64'd0);
        expect_en = 1'b1;

        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/approx_mul_err_monitor.md
Name: approx_mul_err_monitor

Overview:
- Sequential error-statistics stage that sits directly downstream of an 8x8 approximate Dadda multiplier.
- Each accepted sample carries the operand pair and the approximate product the multiplier computed combinationally for those operands.
- The block recomputes the exact product and accumulates signed error sum, squared error sum, maximum absolute error and mismatch count over a programmed number of samples.
- These statistics drive the area/MSE characterisation flow.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- NUM_SAMPLES, 65536, samples per run; must be >= 1.
- ACC_W, 48, width of the squared-error accumulator and signed-error accumulator.
- CNT_W, 17, width of the sample and mismatch counters; must hold NUM_SAMPLES.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; clears statistics and begins a run.
- in_valid  in  1  sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- op_a  in  WIDTH  multiplicand.
- op_b  in  WIDTH  multiplier.
- approx_prod  in  2*WIDTH  approximate product for op_a*op_b.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE; statistics are final.
- sample_cnt  out  CNT_W  samples retired into the accumulators.
- mismatch_cnt  out  CNT_W  retired samples with nonzero error.
- sum_err  out  ACC_W  signed sum of (approx_prod - exact).
- sum_sq_err  out  ACC_W  unsigned sum of squared error.
- max_abs_err  out  2*WIDTH+1  largest absolute error seen.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; pipeline valids cleared.
  - in_ready=0, busy=0, done=0.
  - All counters and accumulators are 0.
  - Reset mid-run discards everything.
- FSM states and transitions:
  - IDLE: start -> RUN.
  - RUN:
    - in_ready = (issued < NUM_SAMPLES). Handshake = in_valid & in_ready.
    - When issued reaches NUM_SAMPLES, go to DRAIN.
  - DRAIN:
    - in_ready=0. Wait until all pipeline valids are 0, then go to DONE.
  - DONE:
    - done=1; outputs hold. start -> RUN.
- start handling:
  - start in any state clears the accumulators, counters, issued count and pipeline valids, and enters RUN the next cycle.
  - In-flight samples are discarded.
  - start takes priority over a simultaneous handshake; that sample is dropped.
- Pipeline (3 stages, no internal stall; in_ready does not depend on downstream):
  - S1: register op_a, op_b, approx_prod and valid on handshake.
  - S2:
    - exact = op_a*op_b (2*WIDTH bits, unsigned).
    - err = zero-extended approx_prod - exact, as (2*WIDTH+1)-bit signed.
    - abs_err = |err|.
  - S3 (accumulate):
    - sum_err += sign-extended err.
    - sum_sq_err += abs_err*abs_err.
    - sample_cnt += 1.
    - mismatch_cnt += (err != 0).
    - max_abs_err = max(max_abs_err, abs_err).
- Latency: a sample accepted at edge t is visible in all statistics after edge t+3.
- Overflow:
  - sum_sq_err saturates at 2^ACC_W-1.
  - sum_err saturates at the signed ACC_W limits.
  - Counters do not wrap; NUM_SAMPLES bounds them.
- Ordering: done rises exactly one cycle after the last sample retires; busy falls in the same cycle.

Optional Feature:
- Macro: ERR_MON_WORST_CASE_EN.
- Defined:
  - Extra outputs worst_a (WIDTH), worst_b (WIDTH) and worst_approx (2*WIDTH), all 0 on reset or start.
  - They are updated in S3 whenever abs_err > max_abs_err (strictly greater), so the first occurrence wins on ties.
  - A sample with abs_err=0 never updates them.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then start, NUM_SAMPLES=4, feed (3,5,15), (255,255,65025), (0,7,0), (1,1,1) -> done after the 4th sample retires; sum_err=0, sum_sq_err=0, mismatch_cnt=0, max_abs_err=0, sample_cnt=4.
- NUM_SAMPLES=3, feed (3,5,13), (10,10,104), (2,2,4) -> sum_err=+2 (i.e. -2+4+0), sum_sq_err=20, mismatch_cnt=2, max_abs_err=4; with ERR_MON_WORST_CASE_EN: worst_a=10, worst_b=10, worst_approx=104.
- Single accept at edge t of (255,255,0) -> sum_err=-65025 and sum_sq_err=4228250625 appear exactly after edge t+3, not before.
- Hold in_valid=1 continuously with NUM_SAMPLES=4 -> in_ready drops after the 4th handshake; no 5th sample is counted; busy=0 and done=1 thereafter.
- Assert start after 2 of 4 samples, with a handshake in the same cycle -> all statistics become 0; the concurrent sample is not counted; the run completes only after 4 further samples.
- Pulse rst_n=0 for one edge during DRAIN -> next cycle in IDLE, all outputs 0; samples supplied before start are ignored (in_ready=0).
